mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between the instruction-fetch stage and the MEM stage (LW/SW) of the five-stage pipeline.
- Arbitrates requests, sequences each memory transaction through a ready handshake, and returns read data to the winner.
- Drives a pipeline stall while the losing requester waits.
- Sits between the cpu pipeline registers and the memory model.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 3, consecutive data grants allowed while fetch is pending before fetch is forced to win; legal range 1..15.
- TIMEOUT, 16, cycles to wait for mem_ready before abort (optional feature only).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request; held until if_valid.
- if_addr  input  AW  fetch address.
- if_valid  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DW  fetched instruction.
- d_req  input  1  data request; held until d_valid.
- d_we  input  1  1 = SW, 0 = LW.
- d_addr  input  AW  data address (ALU result).
- d_wdata  input  DW  store data.
- d_valid  output  1  one-cycle pulse; load data valid or store complete.
- d_rdata  output  DW  load data.
- mem_req  output  1  memory transaction active.
- mem_we  output  1  write enable to memory.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data.
- mem_ready  input  1  memory completes the transaction this cycle.
- stall  output  1  freeze the pipeline.
- err  output  1  sticky timeout error (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async, reset_n=0): state IDLE; starve_cnt=0. mem_req, mem_we, if_valid, d_valid, stall and err are 0. mem_addr, mem_wdata, if_rdata and d_rdata are 0.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - if fetch is forced (if_req && starve_cnt==MAX_WAIT) -> BUSY_IF.
  - else if d_req -> BUSY_D.
  - else if if_req -> BUSY_IF.
  - else stay in IDLE.
- Grant effects:
  - Register the winner's address, we and wdata into mem_addr, mem_we and mem_wdata.
  - mem_req=1 from the next cycle until the completing cycle inclusive.
  - Fetch is never a write (mem_we=0).
- BUSY_x completion: when mem_req && mem_ready, pulse x_valid for exactly one cycle, capture mem_rdata into x_rdata on the same edge, and return to IDLE. The minimum transaction is 3 cycles (grant, access, valid).
- x_rdata holds its value until the next completion for that requester. d_rdata is unchanged on store completion.
- mem_addr, mem_we and mem_wdata stay stable for the whole transaction, regardless of requester inputs.
- starve_cnt:
  - increments on each data grant made while if_req=1, saturating at MAX_WAIT.
  - clears on every fetch grant.
  - holds otherwise.
- stall = (if_req && !if_valid) || (d_req && !d_valid), combinational from the registered valids.
- Simultaneous request and completion: a request arriving in the completion cycle is arbitrated in the following IDLE cycle. There is no back-to-back bypass.
- mem_ready while mem_req=0 is ignored.
- Deasserting a request mid-transaction is illegal; the transaction still completes and valid still pulses.
- Reset mid-transaction aborts immediately: no valid pulse, mem_req drops asynchronously.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in BUSY_IF/BUSY_D. If TIMEOUT cycles pass with mem_req=1 and no mem_ready, the arbiter aborts to IDLE.
  - The owner's x_valid pulses with x_rdata = all-ones.
  - err sets and stays set until reset.
  - The counter clears on every grant.
- Undefined: no counter, the arbiter waits indefinitely, and err is a constant 0.

Test Plan:
- Reset: drive reset_n=0 mid-BUSY_D -> mem_req, d_valid, stall and err are 0 asynchronously; state is IDLE after release.
- Single fetch: if_req with if_addr=0x10, mem_ready returns 1 the cycle after mem_req with mem_rdata=0x0C221803 -> if_valid pulses once with if_rdata=0x0C221803 and mem_we=0; stall is high until that cycle.
- Single store: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF held until mem_ready; d_valid pulses; d_rdata unchanged.
- Priority and starvation (MAX_WAIT=3): if_req and d_req held high continuously, mem_ready immediate -> grant order D, D, D, IF, D, ...; starve_cnt reaches 3 and then clears.
- Wait states: mem_ready delayed 5 cycles on a load from 0x80 returning 0x12345678 -> mem_addr stable for all 5 cycles, exactly one d_valid with d_rdata=0x12345678.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=16): mem_ready never asserted on a fetch -> after 16 cycles if_valid pulses with if_rdata=0xFFFFFFFF, err=1 and stays 1; the next d_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the memory.
// slave is the arbiter view; master is the pipeline/memory side view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall;
    logic          err;

    modport slave (
        input  if_req, if_addr,
        output if_valid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_valid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output stall, err
    );

    modport master (
        output if_req, if_addr,
        input  if_valid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_valid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  stall, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-ported memory with fetch anti-starvation.
// Optional abort-on-timeout with sticky err when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 3,
    parameter int TIMEOUT  = 16
) (
    input logic               clk,
    input logic               reset_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam int SW = $clog2(MAX_WAIT + 1);

    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] starve_cnt;
    logic          grant_if;
    logic          grant_d;
    logic          done;
    logic          busy;
    logic          force_if;
    logic          tmo_hit;
    logic          err_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic          if_valid_q;
    logic          d_valid_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic [DW-1:0] rdata_in;

    assign busy     = (state_q != IDLE);
    assign force_if = bus.if_req && (starve_cnt == SW'(MAX_WAIT));
    // An aborted transaction returns all-ones instead of memory data.
    assign rdata_in = bus.mem_ready ? bus.mem_rdata : '1;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = busy && !bus.mem_ready &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant_if || grant_d) begin
                tmo_cnt <= '0;
            end else if (busy && !bus.mem_ready) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    logic cfg_unused;

    assign cfg_unused = (TIMEOUT > 0);
    assign tmo_hit    = 1'b0;
    assign err_q      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_if = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (force_if) begin
                    grant_if = 1'b1;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                end else if (bus.if_req) begin
                    grant_if = 1'b1;
                end
                if (grant_if) begin
                    state_d = BUSY_IF;
                end else if (grant_d) begin
                    state_d = BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (bus.mem_ready || tmo_hit) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_valid_q <= done && (state_q == BUSY_IF);
            d_valid_q  <= done && (state_q == BUSY_D);
            if (grant_if) begin
                addr_q <= bus.if_addr;
                we_q   <= 1'b0;
            end else if (grant_d) begin
                addr_q  <= bus.d_addr;
                we_q    <= bus.d_we;
                wdata_q <= bus.d_wdata;
            end
            if (done && (state_q == BUSY_IF)) begin
                if_rdata_q <= rdata_in;
            end
            // A completed store leaves the load data untouched.
            if (done && (state_q == BUSY_D) && (!we_q || tmo_hit)) begin
                d_rdata_q <= rdata_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.if_req &&
                     (starve_cnt != SW'(MAX_WAIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.mem_req   = busy;
        bus.mem_we    = we_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.if_valid  = if_valid_q;
        bus.if_rdata  = if_rdata_q;
        bus.d_valid   = d_valid_q;
        bus.d_rdata   = d_rdata_q;
        bus.err       = err_q;
        bus.stall     = reset_n &&
                        ((bus.if_req && !if_valid_q) ||
                         (bus.d_req && !d_valid_q));
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter with a transaction-level model.
// Directed cases pin the model with literal expectations.
module tb_mem_port_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 3;
    localparam int TIMEOUT  = 16;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Memory responder: fixed latency or random ready, fixed or random data.
    int          rdy_delay = 0;
    bit          rdy_rand  = 0;
    bit          rd_rand   = 0;
    logic [31:0] rd_fixed  = 32'h0;
    int          wcnt      = 0;

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            wcnt = bus.mem_req ? wcnt + 1 : 0;
            if (rdy_rand) begin
                bus.mem_ready = 1'($urandom_range(0, 1));
            end else begin
                bus.mem_ready = bus.mem_req && (wcnt > rdy_delay);
            end
            bus.mem_rdata = rd_rand ? $urandom : rd_fixed;
        end
    end

    // Transaction-level model: who owns the memory and what it will return.
    int          owner;
    int          starve;
    int          waitc;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    bit          e_ifv;
    bit          e_dv;
    bit          e_err;
    logic [31:0] e_ifr;
    logic [31:0] e_dr;
    bit          n_ifv;
    bit          n_dv;

    task automatic model_reset();
        owner  = 0;
        starve = 0;
        waitc  = 0;
        m_addr = 0;
        m_wdata = 0;
        m_we   = 0;
        e_ifv  = 0;
        e_dv   = 0;
        e_err  = 0;
        e_ifr  = 0;
        e_dr   = 0;
    endtask

    task automatic model_complete(input logic [31:0] data, input bit aborted);
        if (owner == 1) begin
            n_ifv = 1;
            e_ifr = data;
        end else begin
            n_dv = 1;
            if (!m_we || aborted) e_dr = data;
        end
        owner = 0;
    endtask

    task automatic grant_fetch();
        owner  = 1;
        m_addr = bus.if_addr;
        m_we   = 0;
        starve = 0;
        waitc  = 0;
    endtask

    task automatic model_step();
        n_ifv = 0;
        n_dv  = 0;
        if (owner == 0) begin
            if (bus.if_req && starve == MAX_WAIT) begin
                grant_fetch();
            end else if (bus.d_req) begin
                if (bus.if_req && starve < MAX_WAIT) starve++;
                owner   = 2;
                m_addr  = bus.d_addr;
                m_we    = bus.d_we;
                m_wdata = bus.d_wdata;
                waitc   = 0;
            end else if (bus.if_req) begin
                grant_fetch();
            end
        end else if (bus.mem_ready) begin
            model_complete(bus.mem_rdata, 0);
        end else begin
`ifdef MEM_ARB_TIMEOUT_EN
            waitc++;
            if (waitc == TIMEOUT) begin
                model_complete(32'hFFFF_FFFF, 1);
                e_err = 1;
            end
`endif
        end
        e_ifv = n_ifv;
        e_dv  = n_dv;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!reset_n) model_reset();
            check("mem_req", bus.mem_req, 32'(owner != 0));
            if (owner != 0) begin
                check("mem_addr", bus.mem_addr, m_addr);
                check("mem_we", bus.mem_we, m_we);
                if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
            end
            check("if_valid", bus.if_valid, e_ifv);
            check("d_valid", bus.d_valid, e_dv);
            check("if_rdata", bus.if_rdata, e_ifr);
            check("d_rdata", bus.d_rdata, e_dr);
            check("err", bus.err, e_err);
            check("stall", bus.stall,
                  reset_n && ((bus.if_req && !e_ifv) || (bus.d_req && !e_dv)));
            if (reset_n) model_step();
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_req(input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int bound, output logic [31:0] rd,
                           output int busy_n, output int bad_n, output bit ok);
        busy_n = 0;
        bad_n  = 0;
        ok     = 0;
        rd     = 0;
        if (is_d) begin
            bus.d_req = 1; bus.d_we = we;
            bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1; bus.if_addr = addr;
        end
        for (int i = 0; i < bound && !ok; i++) begin
            cyc(1);
            if (bus.mem_req) begin
                busy_n++;
                if (bus.mem_addr !== addr || bus.mem_we !== we ||
                    (we && bus.mem_wdata !== wdata)) bad_n++;
            end
            if (is_d ? bus.d_valid : bus.if_valid) begin
                ok = 1;
                rd = is_d ? bus.d_rdata : bus.if_rdata;
            end
        end
        if (is_d) bus.d_req = 0;
        else bus.if_req = 0;
    endtask

    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            cyc(1);
            if (bus.if_valid || bus.d_valid) cnt++;
        end
    endtask

    logic [31:0] rd;
    int          busy_n;
    int          bad_n;
    int          vcnt;
    bit          ok;
    logic [31:0] order [8];
    logic [31:0] exp_order [8];
    int          nrec;
    bit          prev_req;

    initial begin
        reset_n = 0;
        bus.if_req = 0; bus.if_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
        #7;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_if_rdata", bus.if_rdata, 0);
        check("rst_stall", bus.stall, 0);
        cyc(2);
        reset_n = 1;
        cyc(2);

        // Reset in the middle of a stalled store.
        rdy_delay = 1000;
        bus.d_req = 1; bus.d_we = 1;
        bus.d_addr = 32'h40; bus.d_wdata = 32'h1111_2222;
        for (int i = 0; i < 10 && !bus.mem_req; i++) cyc(1);
        cyc(2);
        check("pre_rst_mem_req", bus.mem_req, 1);
        #2;
        reset_n = 0;
        #1;
        check("arst_mem_req", bus.mem_req, 0);
        check("arst_d_valid", bus.d_valid, 0);
        check("arst_stall", bus.stall, 0);
        check("arst_err", bus.err, 0);
        bus.d_req = 0;
        cyc(1);
        reset_n = 1;
        cyc(3);
        check("post_rst_idle", bus.mem_req, 0);
        rdy_delay = 0;

        rd_fixed = 32'h0C22_1803;
        run_req(0, 0, 32'h10, 0, 20, rd, busy_n, bad_n, ok);
        check("fetch_done", ok, 1);
        check("fetch_rdata", rd, 32'h0C22_1803);
        check("fetch_busy", busy_n, 1);
        check("fetch_bus", bad_n, 0);
        count_valids(4, vcnt);
        check("fetch_once", vcnt, 0);
        check("fetch_hold", bus.if_rdata, 32'h0C22_1803);

        rd_fixed = 32'h5555_5555;
        run_req(1, 1, 32'h40, 32'hDEAD_BEEF, 20, rd, busy_n, bad_n, ok);
        check("store_done", ok, 1);
        check("store_rdata", rd, 32'h0);
        check("store_bus", bad_n, 0);

        rdy_delay = 5;
        rd_fixed  = 32'h1234_5678;
        run_req(1, 0, 32'h80, 0, 30, rd, busy_n, bad_n, ok);
        check("wait_done", ok, 1);
        check("wait_rdata", rd, 32'h1234_5678);
        check("wait_busy", busy_n, 6);
        check("wait_bus", bad_n, 0);
        count_valids(4, vcnt);
        check("wait_once", vcnt, 0);
        rdy_delay = 0;

        // Both requesters held: data wins until fetch has waited MAX_WAIT grants.
        exp_order = '{32'h200, 32'h200, 32'h200, 32'h100,
                      32'h200, 32'h200, 32'h200, 32'h100};
        bus.if_addr = 32'h100; bus.d_addr = 32'h200; bus.d_we = 0;
        bus.if_req = 1; bus.d_req = 1;
        nrec = 0;
        prev_req = 0;
        for (int i = 0; i < 80 && nrec < 8; i++) begin
            cyc(1);
            if (bus.mem_req && !prev_req) begin
                order[nrec] = bus.mem_addr;
                nrec++;
            end
            prev_req = bus.mem_req;
        end
        check("starve_grants", nrec, 8);
        for (int i = 0; i < 8; i++) check("starve_order", order[i], exp_order[i]);
        for (int i = 0; i < 30 && (bus.if_req || bus.d_req); i++) begin
            cyc(1);
            if (bus.d_valid) bus.d_req = 0;
            if (bus.if_valid) bus.if_req = 0;
        end
        check("starve_drain", {bus.if_req, bus.d_req}, 0);
        cyc(2);

`ifdef MEM_ARB_TIMEOUT_EN
        rdy_delay = 1000;
        run_req(0, 0, 32'h300, 0, 40, rd, busy_n, bad_n, ok);
        check("tmo_done", ok, 1);
        check("tmo_rdata", rd, 32'hFFFF_FFFF);
        check("tmo_busy", busy_n, TIMEOUT);
        check("tmo_err", bus.err, 1);
        rdy_delay = 0;
        rd_fixed  = 32'hA5A5_A5A5;
        run_req(1, 0, 32'h304, 0, 20, rd, busy_n, bad_n, ok);
        check("after_tmo_done", ok, 1);
        check("after_tmo_rdata", rd, 32'hA5A5_A5A5);
        check("err_sticky", bus.err, 1);
`endif

        rdy_rand = 1;
        rd_rand  = 1;
        repeat (2000) begin
            cyc(1);
            if (bus.if_req) begin
                if (bus.if_valid) bus.if_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.if_req  = 1;
                bus.if_addr = $urandom;
            end
            if (bus.d_req) begin
                if (bus.d_valid) bus.d_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.d_req   = 1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
        end
        for (int i = 0; i < 300 && (bus.if_req || bus.d_req); i++) begin
            cyc(1);
            if (bus.d_valid) bus.d_req = 0;
            if (bus.if_valid) bus.if_req = 0;
        end
        check("rand_drain", {bus.if_req, bus.d_req}, 0);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
